// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing generator gated by a qualified PLL lock.
// Optional frame counter output is enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int SYNC_POL  = 0,
    parameter int LOCK_WAIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start,
    output logic       running
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int WAIT_W = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT + 1) : 1;

    localparam logic [9:0] H_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_ACT_L   = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_L   = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEGIN  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEGIN  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LOCK_WAIT - 1);
    localparam logic SYNC_ON = (SYNC_POL != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RUN
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic                r_lkMeta;
    logic                r_lkSync;
    logic [WAIT_W-1:0]   r_waitCnt;
    logic [WAIT_W-1:0]   w_nextWait;
    logic [9:0]          r_hCnt;
    logic [9:0]          r_vCnt;
    logic [9:0]          w_nextH;
    logic [9:0]          w_nextV;
    logic                w_run;
    logic                w_de;
    logic                w_hsOn;
    logic                w_vsOn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lkMeta <= 1'b0;
            r_lkSync <= 1'b0;
        end else begin
            r_lkMeta <= pll_locked;
            r_lkSync <= r_lkMeta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_waitCnt <= '0;
            r_hCnt    <= '0;
            r_vCnt    <= '0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= w_nextWait;
            r_hCnt    <= w_nextH;
            r_vCnt    <= w_nextV;
        end
    end

    // Counters are zero outside RUN, so entering RUN always starts at h=0, v=0.
    always_comb begin
        w_nextState = r_state;
        w_nextWait  = '0;
        w_nextH     = '0;
        w_nextV     = '0;
        case (r_state)
            ST_IDLE: begin
                if (r_lkSync) w_nextState = ST_WAIT;
            end
            ST_WAIT: begin
                if (!r_lkSync)
                    w_nextState = ST_IDLE;
                else if (r_waitCnt == WAIT_LAST)
                    w_nextState = ST_RUN;
                else
                    w_nextWait = r_waitCnt + 1'b1;
            end
            ST_RUN: begin
                if (!r_lkSync) begin
                    w_nextState = ST_IDLE;
                end else if (r_hCnt == H_LAST) begin
                    w_nextH = '0;
                    w_nextV = (r_vCnt == V_LAST) ? 10'd0 : r_vCnt + 10'd1;
                end else begin
                    w_nextH = r_hCnt + 10'd1;
                    w_nextV = r_vCnt;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_comb begin
        w_run  = (w_nextState == ST_RUN);
        w_de   = w_run && (w_nextH < H_ACT_L) && (w_nextV < V_ACT_L);
        w_hsOn = w_run && (w_nextH >= HS_BEGIN) && (w_nextH < HS_END);
        w_vsOn = w_run && (w_nextV >= VS_BEGIN) && (w_nextV < VS_END);
    end

    // Outputs decode the next counter values so they line up with h_cnt/v_cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= ~SYNC_ON;
            vsync       <= ~SYNC_ON;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            running     <= 1'b0;
        end else begin
            hsync       <= w_hsOn ? SYNC_ON : ~SYNC_ON;
            vsync       <= w_vsOn ? SYNC_ON : ~SYNC_ON;
            de          <= w_de;
            x           <= w_de ? w_nextH : 10'd0;
            y           <= w_de ? w_nextV : 10'd0;
            line_start  <= w_run && (w_nextH == 10'd0);
            frame_start <= w_run && (w_nextH == 10'd0) && (w_nextV == 10'd0);
            running     <= w_run;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    // The frame_start that opens a RUN session is frame 0 and does not count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            frame_cnt <= '0;
        else if (!w_run)
            frame_cnt <= '0;
        else if ((r_state == ST_RUN) && (w_nextH == 10'd0) && (w_nextV == 10'd0))
            frame_cnt <= frame_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-size raster for bring-up and line timing, reduced-size raster for frame-level checks.
module tb_vga_timing_gen;

    logic       clk;
    logic       rstD, lockD, rstS, lockS;
    logic       dHs, dVs, dDe, dLs, dFs, dRun;
    logic [9:0] dX, dY;
    logic       sHs, sVs, sDe, sLs, sFs, sRun;
    logic [9:0] sX, sY;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] dFc, sFc;
`endif
    int checks = 0;
    int errors = 0;

    vga_timing_gen u_dut (
        .clk(clk), .rst_n(rstD), .pll_locked(lockD),
        .hsync(dHs), .vsync(dVs), .de(dDe), .x(dX), .y(dY),
        .line_start(dLs), .frame_start(dFs), .running(dRun)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(dFc)
`endif
    );

    // Small raster: 16 cycles per line, 12 lines per frame, 4-cycle lock qualification.
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(0), .LOCK_WAIT(4)
    ) u_small (
        .clk(clk), .rst_n(rstS), .pll_locked(lockS),
        .hsync(sHs), .vsync(sVs), .de(sDe), .x(sX), .y(sY),
        .line_start(sLs), .frame_start(sFs), .running(sRun)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(sFc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rstD = 1'b0; rstS = 1'b0; lockD = 1'b1; lockS = 1'b1;
        step(5);
        checks++; if (dRun !== 1'b0) begin errors++; $display("[TB] FAIL reset_running got %b expected 0", dRun); end
        checks++; if ({dHs, dVs} !== 2'b11) begin errors++; $display("[TB] FAIL reset_sync got %b expected 11", {dHs, dVs}); end
        checks++; if ({dDe, dLs, dFs} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags got %b expected 000", {dDe, dLs, dFs}); end
        checks++; if ({dX, dY} !== 20'd0) begin errors++; $display("[TB] FAIL reset_xy got %0d/%0d expected 0/0", dX, dY); end
        checks++; if ({sRun, sHs, sVs} !== 3'b011) begin errors++; $display("[TB] FAIL reset_small got %b expected 011", {sRun, sHs, sVs}); end
    endtask

    task automatic test_bringup();
        rstD = 1'b1;
        step(18);
        checks++; if (dRun !== 1'b0) begin errors++; $display("[TB] FAIL bringup_early got running=%b expected 0", dRun); end
        step(1);
        checks++; if (dRun !== 1'b1) begin errors++; $display("[TB] FAIL bringup_run got running=%b expected 1", dRun); end
        checks++; if ({dFs, dLs, dDe, dHs} !== 4'b1111) begin errors++; $display("[TB] FAIL bringup_flags got %b expected 1111", {dFs, dLs, dDe, dHs}); end
        checks++; if ({dX, dY} !== 20'd0) begin errors++; $display("[TB] FAIL bringup_xy got %0d/%0d expected 0/0", dX, dY); end
    endtask

    task automatic test_line_timing();
        int deCnt = 0, hsCnt = 0, hsFirst = -1, hsLast = -1, lsCnt = 0, xBad = 0;
        for (int c = 0; c < 800; c++) begin
            if (dDe === 1'b1) begin
                deCnt++;
                if (dX !== 10'(c)) xBad++;
            end
            if (dHs === 1'b0) begin
                hsCnt++;
                if (hsFirst < 0) hsFirst = c;
                hsLast = c;
            end
            if (dLs === 1'b1) lsCnt++;
            step(1);
        end
        checks++; if (deCnt != 640) begin errors++; $display("[TB] FAIL line_de_count got %0d expected 640", deCnt); end
        checks++; if (xBad != 0) begin errors++; $display("[TB] FAIL line_x_value got %0d bad cycles expected 0", xBad); end
        checks++; if (hsCnt != 96) begin errors++; $display("[TB] FAIL line_hs_count got %0d expected 96", hsCnt); end
        checks++; if (hsFirst != 656 || hsLast != 751) begin errors++; $display("[TB] FAIL line_hs_window got %0d..%0d expected 656..751", hsFirst, hsLast); end
        checks++; if (lsCnt != 1) begin errors++; $display("[TB] FAIL line_ls_count got %0d expected 1", lsCnt); end
        checks++; if ({dLs, dFs, dDe} !== 3'b101) begin errors++; $display("[TB] FAIL line_wrap_flags got %b expected 101", {dLs, dFs, dDe}); end
        checks++; if (dY !== 10'd1 || dX !== 10'd0) begin errors++; $display("[TB] FAIL line_wrap_xy got %0d/%0d expected 0/1", dX, dY); end
    endtask

    task automatic test_lock_glitch();
        rstD = 1'b0;
        step(2);
        rstD = 1'b1;
        step(13);
        lockD = 1'b0;
        step(3);
        lockD = 1'b1;
        step(3);
        checks++; if (dRun !== 1'b0) begin errors++; $display("[TB] FAIL glitch_no_run got running=%b expected 0", dRun); end
        step(15);
        checks++; if (dRun !== 1'b0) begin errors++; $display("[TB] FAIL glitch_early got running=%b expected 0", dRun); end
        step(1);
        checks++; if ({dRun, dFs} !== 2'b11) begin errors++; $display("[TB] FAIL glitch_run got %b expected 11", {dRun, dFs}); end
    endtask

    task automatic test_frame_timing();
        int deCnt = 0, hsCnt = 0, vsCnt = 0, vsFirst = -1, fsCnt = 0, lsCnt = 0, yBad = 0;
        rstS = 1'b1;
        step(6);
        checks++; if (sRun !== 1'b0) begin errors++; $display("[TB] FAIL frame_early got running=%b expected 0", sRun); end
        step(1);
        checks++; if ({sRun, sFs} !== 2'b11) begin errors++; $display("[TB] FAIL frame_run got %b expected 11", {sRun, sFs}); end
`ifdef VGA_FRAME_CNT_EN
        checks++; if (sFc !== 16'd0) begin errors++; $display("[TB] FAIL frame_cnt_first got %0d expected 0", sFc); end
`endif
        for (int c = 0; c < 192; c++) begin
            if (sDe === 1'b1) begin
                deCnt++;
                if (sY !== 10'(c / 16) || sX !== 10'(c % 16)) yBad++;
            end
            if (sHs === 1'b0) hsCnt++;
            if (sVs === 1'b0) begin
                vsCnt++;
                if (vsFirst < 0) vsFirst = c;
            end
            if (sFs === 1'b1) fsCnt++;
            if (sLs === 1'b1) lsCnt++;
            step(1);
        end
        checks++; if (deCnt != 48) begin errors++; $display("[TB] FAIL frame_de_count got %0d expected 48", deCnt); end
        checks++; if (yBad != 0) begin errors++; $display("[TB] FAIL frame_xy_value got %0d bad cycles expected 0", yBad); end
        checks++; if (hsCnt != 36) begin errors++; $display("[TB] FAIL frame_hs_count got %0d expected 36", hsCnt); end
        checks++; if (vsCnt != 32) begin errors++; $display("[TB] FAIL frame_vs_count got %0d expected 32", vsCnt); end
        checks++; if (vsFirst != 128) begin errors++; $display("[TB] FAIL frame_vs_start got %0d expected 128", vsFirst); end
        checks++; if (fsCnt != 1 || lsCnt != 12) begin errors++; $display("[TB] FAIL frame_strobes got fs=%0d ls=%0d expected 1/12", fsCnt, lsCnt); end
        checks++; if ({sFs, sLs} !== 2'b11) begin errors++; $display("[TB] FAIL frame_wrap got %b expected 11", {sFs, sLs}); end
`ifdef VGA_FRAME_CNT_EN
        checks++; if (sFc !== 16'd1) begin errors++; $display("[TB] FAIL frame_cnt_second got %0d expected 1", sFc); end
`endif
    endtask

    task automatic test_async_reset();
        step(192);
`ifdef VGA_FRAME_CNT_EN
        checks++; if (sFc !== 16'd2) begin errors++; $display("[TB] FAIL frame_cnt_third got %0d expected 2", sFc); end
`endif
        step(5);
        checks++; if ({sRun, sDe} !== 2'b11 || sX !== 10'd5) begin errors++; $display("[TB] FAIL areset_pre got run/de=%b x=%0d expected 11/5", {sRun, sDe}, sX); end
        #2 rstS = 1'b0;
        #1;
        checks++; if ({sRun, sDe, sLs, sFs} !== 4'b0000) begin errors++; $display("[TB] FAIL areset_flags got %b expected 0000", {sRun, sDe, sLs, sFs}); end
        checks++; if ({sHs, sVs} !== 2'b11 || {sX, sY} !== 20'd0) begin errors++; $display("[TB] FAIL areset_outs got sync=%b x=%0d y=%0d expected 11/0/0", {sHs, sVs}, sX, sY); end
`ifdef VGA_FRAME_CNT_EN
        checks++; if (sFc !== 16'd0) begin errors++; $display("[TB] FAIL areset_frame_cnt got %0d expected 0", sFc); end
`endif
        step(1);
    endtask

    task automatic test_lock_loss();
        rstS = 1'b1;
        step(7);
        checks++; if (sRun !== 1'b1) begin errors++; $display("[TB] FAIL loss_bringup got running=%b expected 1", sRun); end
        step(69);
        checks++; if (sX !== 10'd5 || sY !== 10'd4 || sDe !== 1'b1) begin errors++; $display("[TB] FAIL loss_position got x=%0d y=%0d de=%b expected 5/4/1", sX, sY, sDe); end
        lockS = 1'b0;
        step(2);
        checks++; if (sRun !== 1'b1) begin errors++; $display("[TB] FAIL loss_sync_delay got running=%b expected 1", sRun); end
        step(1);
        checks++; if ({sRun, sDe, sHs, sVs} !== 4'b0011 || {sX, sY} !== 20'd0) begin errors++; $display("[TB] FAIL loss_idle got %b x=%0d y=%0d expected 0011/0/0", {sRun, sDe, sHs, sVs}, sX, sY); end
`ifdef VGA_FRAME_CNT_EN
        checks++; if (sFc !== 16'd0) begin errors++; $display("[TB] FAIL loss_frame_cnt got %0d expected 0", sFc); end
`endif
        lockS = 1'b1;
        step(6);
        checks++; if (sRun !== 1'b0) begin errors++; $display("[TB] FAIL relock_early got running=%b expected 0", sRun); end
        step(1);
        checks++; if ({sRun, sFs} !== 2'b11 || {sX, sY} !== 20'd0) begin errors++; $display("[TB] FAIL relock_run got %b x=%0d y=%0d expected 11/0/0", {sRun, sFs}, sX, sY); end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_line_timing();
        test_lock_glitch();
        test_frame_timing();
        test_async_reset();
        test_lock_loss();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Consumes the 25.175 MHz pixel clock and `locked` flag from the VGA PLL stage.
- Generates 640x480@60 raster timing: hsync, vsync, display enable, pixel coordinates and frame/line strobes for the pixel-fetch stage downstream.
- Holds the raster idle until the PLL has been locked for a qualified interval.
- Drops back to idle whenever lock is lost.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 96, hsync width (cycles)
- H_BP, 48, horizontal back porch (cycles)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)
- LOCK_WAIT, 16, consecutive synchronized-locked cycles required before running

Ports:
- clk  in  1  pixel clock (PLL outclk_0)
- rst_n  in  1  asynchronous, active-low reset
- pll_locked  in  1  PLL lock flag; asynchronous to clk
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  display enable: active-pixel region
- x  out  10  pixel column; 0 outside the active region
- y  out  10  pixel row; 0 outside the active region
- line_start  out  1  one-cycle pulse at h=0 of every line
- frame_start  out  1  one-cycle pulse at h=0, v=0
- running  out  1  raster active (state RUN)

Behaviour:
- Reset: one clock, `clk`. Reset is asynchronous and active-low on `rst_n`; all flops clear immediately on assertion.
  - Reset values: hsync = vsync = !SYNC_POL (deasserted); de, x, y, line_start, frame_start, running = 0; state IDLE; counters 0.
- Lock synchronization: pll_locked passes through a 2-flop synchronizer to form lk_s; lk_s is the only use of the lock flag.
- Derived widths:
  - H_TOTAL = sum of the H_* parameters = 800; V_TOTAL = sum of the V_* parameters = 525.
  - h_cnt and v_cnt are 10 bits.
- FSM:
  - IDLE: wait_cnt = 0. If lk_s = 1, go to WAIT.
  - WAIT: wait_cnt increments while lk_s = 1.
    - If lk_s = 0, return to IDLE and clear wait_cnt.
    - When wait_cnt = LOCK_WAIT-1 with lk_s = 1, go to RUN with h_cnt = v_cnt = 0.
  - RUN: counters advance every cycle.
    - If lk_s = 0, go to IDLE on the next edge.
    - On that edge, all outputs return to reset values and counters clear. The current line or frame is not completed.
- Counters (RUN only):
  - h_cnt wraps from H_TOTAL-1 to 0.
  - v_cnt increments when h_cnt wraps, and wraps from V_TOTAL-1 to 0 on the same edge.
- Output decode: all outputs are registered and reflect the counter value held in the same cycle. Outputs are decoded from next-state counters, so the output latency relative to h_cnt is zero.
  - de = (h < H_ACTIVE) && (v < V_ACTIVE).
  - hsync asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
  - vsync asserted for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491, for the full lines.
  - x = h and y = v when de = 1; both are 0 otherwise.
  - line_start = (h == 0). frame_start = (h == 0 && v == 0).
  - running = 1 in RUN. The first RUN cycle is h=0, v=0, with frame_start = line_start = de = 1.
- Outside RUN: hsync/vsync deasserted, all other outputs 0.
- Boundaries:
  - Lock glitch shorter than LOCK_WAIT during WAIT restarts qualification.
  - Reset mid-frame forces IDLE immediately.
  - pll_locked already high at reset release: RUN is entered exactly 2 + 1 + LOCK_WAIT cycles later (synchronizer, IDLE, WAIT).

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- Defined:
  - Adds output port frame_cnt (out, 16 bits).
  - Increments, wrapping at 0xFFFF -> 0, on each frame_start pulse after the first in a RUN session. The first frame is frame 0.
  - Clears to 0 on reset and on every exit from RUN.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Lock bring-up: rst_n low 5 cycles, pll_locked = 1 throughout -> running rises exactly 19 cycles after rst_n release, with frame_start = 1 and x = y = 0 in that cycle.
- Line timing: run 800 cycles in RUN ->
  - de high for exactly 640 cycles (x = 0..639).
  - hsync low for h = 656..751 (96 cycles).
  - line_start pulses at cycles 0 and 800.
- Frame timing: run 420000 cycles ->
  - vsync low for 1600 cycles starting at v = 490, h = 0.
  - Exactly 307200 de-high cycles.
  - frame_start pulses at cycle 0 and cycle 420000 only.
- Lock glitch in WAIT: pll_locked low for 3 cycles at wait_cnt = 10 -> return to IDLE; running rises only after 16 fresh consecutive locked cycles.
- Lock loss mid-frame: drop pll_locked at v = 200, h = 300 -> within 3 cycles running = 0, de = 0, hsync = vsync = 1, x = y = 0. Re-lock restarts at h = v = 0.
- Async reset mid-line (plus VGA_FRAME_CNT_EN): after 3 frames frame_cnt = 2; assert rst_n between clock edges -> all outputs at reset values before the next edge, and frame_cnt = 0.
